nw_scheduler: RTL and testbench

Job scheduler and flow controller for the Needleman-Wunsch systolic grid. Accepts tagged string pairs over a valid/ready stream and issues at most one pair per cycle into the grid, which has fixed latency and cannot stall. It carries each tag alongside its job and collects grid scores into an output FIFO that drains over a valid/ready stream. Credit accounting guarantees the FIFO never overflows, so no in-flight result is ever lost.

---
 rtl/nw_scheduler_if.sv | 45 ++++
 rtl/nw_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_nw_scheduler.sv | 379 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nw_scheduler_if.sv
// Job, grid and result streams of the NW scheduler.
// slave: scheduler side; master: producer/grid/consumer side.
interface nw_scheduler_if #(
  parameter int S_LEN     = 64,
  parameter int C_WIDTH   = 2,
  parameter int S_WIDTH   = 8,
  parameter int TAG_WIDTH = 8
);
  localparam int SW = S_LEN * C_WIDTH;

  logic                 in_valid;
  logic                 in_ready;
  logic [TAG_WIDTH-1:0] in_tag;
  logic [SW-1:0]        in_t_str;
  logic [SW-1:0]        in_l_str;

  logic                 grid_valid_in;
  logic [SW-1:0]        grid_t_str;
  logic [SW-1:0]        grid_l_str;
  logic                 grid_valid_out;
  logic [S_WIDTH-1:0]   grid_score;

  logic                 out_valid;
  logic                 out_ready;
  logic [TAG_WIDTH-1:0] out_tag;
  logic [S_WIDTH-1:0]   out_score;

  modport slave (
    input  in_valid, in_tag, in_t_str, in_l_str,
    output in_ready,
    output grid_valid_in, grid_t_str, grid_l_str,
    input  grid_valid_out, grid_score,
    output out_valid, out_tag, out_score,
    input  out_ready
  );

  modport master (
    output in_valid, in_tag, in_t_str, in_l_str,
    input  in_ready,
    input  grid_valid_in, grid_t_str, grid_l_str,
    output grid_valid_out, grid_score,
    input  out_valid, out_tag, out_score,
    output out_ready
  );
endinterface

// File: rtl/nw_scheduler.sv
// NW grid job scheduler: credit-based issue, tag pipe, result FIFO.
// Ports: clk/rst, enable/drain, bus (job/grid/result), status outputs.
module nw_scheduler #(
  parameter int S_LEN     = 64,
  parameter int C_WIDTH   = 2,
  parameter int S_WIDTH   = 8,
  parameter int TAG_WIDTH = 8,
  parameter int LATENCY   = 2 * S_LEN,
  parameter int OUT_DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic                       drain,
  nw_scheduler_if.slave              bus,
  output logic                       busy,
  output logic [$clog2(OUT_DEPTH):0] used,
  output logic [31:0]                issued,
  output logic [31:0]                completed,
  output logic                       err
);
  localparam int SW = S_LEN * C_WIDTH;
  localparam int PW = $clog2(OUT_DEPTH);
  localparam int UW = PW + 1;
  localparam int EW = TAG_WIDTH + S_WIDTH;
  localparam logic [UW-1:0] DEPTH_U = UW'(OUT_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_e;

  state_e state_q;

  logic [UW-1:0]        used_q, used_d;
  logic [31:0]          iss_q, iss_d;
  logic [31:0]          cmp_q, cmp_d;
  logic                 gv_q, gv_d;
  logic [SW-1:0]        gt_q, gt_d;
  logic [SW-1:0]        gl_q, gl_d;
  logic [TAG_WIDTH-1:0] itag_q, itag_d;
  logic [LATENCY-1:0]   pv_q, pv_d;
  logic [TAG_WIDTH-1:0] pt_q [LATENCY];
  logic [TAG_WIDTH-1:0] pt_d [LATENCY];
  logic [EW-1:0]        mem_q [OUT_DEPTH];
  logic [EW-1:0]        mem_d [OUT_DEPTH];
  logic [PW-1:0]        wp_q, wp_d;
  logic [PW-1:0]        rp_q, rp_d;
  logic [UW-1:0]        cnt_q, cnt_d;
  logic                 err_q, err_d;

  logic in_ready;
  logic out_valid;
  logic accept;
  logic pop;
  logic full;
  logic wr_ok;

  // Ready never looks at in_valid; the credit limit keeps the
  // FIFO from overflowing even with every issued job in flight.
  assign in_ready = (state_q == RUN) && enable && !drain
                    && (used_q < DEPTH_U);
  assign out_valid = (cnt_q != '0);
  assign accept    = bus.in_valid && in_ready;
  assign pop       = out_valid && bus.out_ready;
  assign full      = (cnt_q == DEPTH_U);
  assign wr_ok     = bus.grid_valid_out && !full;

  assign bus.in_ready      = in_ready;
  assign bus.grid_valid_in = gv_q;
  assign bus.grid_t_str    = gt_q;
  assign bus.grid_l_str    = gl_q;
  assign bus.out_valid     = out_valid;
  assign {bus.out_tag, bus.out_score} = mem_q[rp_q];

  assign busy      = (state_q != IDLE);
  assign used      = used_q;
  assign issued    = iss_q;
  assign completed = cmp_q;
  assign err       = err_q;

  always_comb begin
    used_d = used_q;
    if (accept && !pop)
      used_d = used_q + 1'b1;
    else if (pop && !accept)
      used_d = used_q - 1'b1;

    iss_d = iss_q + {31'd0, accept};
    cmp_d = cmp_q + {31'd0, pop};

    gv_d   = accept;
    gt_d   = gt_q;
    gl_d   = gl_q;
    itag_d = itag_q;
    if (accept) begin
      gt_d   = bus.in_t_str;
      gl_d   = bus.in_l_str;
      itag_d = bus.in_tag;
    end

    // Tag pipe mirrors the grid's valid chain stage for stage.
    pv_d[0] = gv_q;
    pt_d[0] = itag_q;
    for (int i = 1; i < LATENCY; i++) begin
      pv_d[i] = pv_q[i-1];
      pt_d[i] = pt_q[i-1];
    end

    err_d = err_q
          | (bus.grid_valid_out != pv_q[LATENCY-1])
          | (bus.grid_valid_out && full);

    mem_d = mem_q;
    wp_d  = wp_q;
    if (wr_ok) begin
      mem_d[wp_q] = {pt_q[LATENCY-1], bus.grid_score};
      wp_d        = wp_q + 1'b1;
    end
    rp_d = pop ? rp_q + 1'b1 : rp_q;

    cnt_d = cnt_q;
    if (wr_ok && !pop)
      cnt_d = cnt_q + 1'b1;
    else if (pop && !wr_ok)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      unique case (state_q)
        IDLE:
          if (enable && !drain)
            state_q <= RUN;
        RUN:
          if (drain || (!enable && used_q != '0))
            state_q <= DRAIN;
          else if (!enable)
            state_q <= IDLE;
        DRAIN:
          if (used_q == '0)
            state_q <= IDLE;
        default:
          state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      used_q <= '0;
      iss_q  <= '0;
      cmp_q  <= '0;
      gv_q   <= 1'b0;
      gt_q   <= '0;
      gl_q   <= '0;
      itag_q <= '0;
      pv_q   <= '0;
      for (int i = 0; i < LATENCY; i++)
        pt_q[i] <= '0;
      for (int i = 0; i < OUT_DEPTH; i++)
        mem_q[i] <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      used_q <= used_d;
      iss_q  <= iss_d;
      cmp_q  <= cmp_d;
      gv_q   <= gv_d;
      gt_q   <= gt_d;
      gl_q   <= gl_d;
      itag_q <= itag_d;
      pv_q   <= pv_d;
      pt_q   <= pt_d;
      mem_q  <= mem_d;
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end
endmodule

// File: tb/tb_nw_scheduler.sv
// Bench for nw_scheduler with a fixed-latency NW grid model.
// Scoreboard queue holds {tag, score} of every accepted job.
module tb_nw_scheduler;
  localparam int S_LEN = 4;
  localparam int C_W   = 2;
  localparam int S_W   = 8;
  localparam int T_W   = 8;
  localparam int LAT   = 2 * S_LEN;
  localparam int DEPTH = 16;
  localparam int SW    = S_LEN * C_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic drain = 1'b0;
  logic spur = 1'b0;
  logic busy, err;
  logic [$clog2(DEPTH):0] used;
  logic [31:0] issued, completed;

  nw_scheduler_if #(
    .S_LEN(S_LEN), .C_WIDTH(C_W),
    .S_WIDTH(S_W), .TAG_WIDTH(T_W)
  ) bus ();

  nw_scheduler #(
    .S_LEN(S_LEN), .C_WIDTH(C_W), .S_WIDTH(S_W),
    .TAG_WIDTH(T_W), .LATENCY(LAT), .OUT_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .drain(drain), .bus(bus), .busy(busy),
    .used(used), .issued(issued),
    .completed(completed), .err(err)
  );

  always #5 clk = ~clk;

  // Golden NW: match +1, mismatch -1, gap -1.
  function automatic logic [S_W-1:0] nw(
    input logic [SW-1:0] t, input logic [SW-1:0] l);
    int h [S_LEN+1][S_LEN+1];
    int d, u, lf, m;
    for (int i = 0; i <= S_LEN; i++) h[i][0] = -i;
    for (int j = 0; j <= S_LEN; j++) h[0][j] = -j;
    for (int i = 1; i <= S_LEN; i++)
      for (int j = 1; j <= S_LEN; j++) begin
        d  = h[i-1][j-1]
           + ((t[(i-1)*C_W +: C_W] == l[(j-1)*C_W +: C_W])
              ? 1 : -1);
        u  = h[i-1][j] - 1;
        lf = h[i][j-1] - 1;
        m  = (d > u) ? d : u;
        h[i][j] = (m > lf) ? m : lf;
      end
    return S_W'(h[S_LEN][S_LEN]);
  endfunction

  // Grid model: LAT-deep valid/score delay line, cleared by rst.
  logic [LAT-1:0] g_v;
  logic [S_W-1:0] g_s [LAT];
  always @(posedge clk) begin
    if (rst) begin
      g_v <= '0;
      for (int i = 0; i < LAT; i++) g_s[i] <= '0;
    end else begin
      g_v[0] <= bus.grid_valid_in;
      g_s[0] <= nw(bus.grid_t_str, bus.grid_l_str);
      for (int i = 1; i < LAT; i++) begin
        g_v[i] <= g_v[i-1];
        g_s[i] <= g_s[i-1];
      end
    end
  end
  assign bus.grid_valid_out = g_v[LAT-1] | spur;
  assign bus.grid_score     = g_s[LAT-1];

  typedef struct {
    logic [T_W-1:0] tag;
    logic [S_W-1:0] score;
  } job_t;

  job_t q [$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int iss_m = 0;
  int cmp_m = 0;
  bit last_acc, last_pop, last_ov;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic expire(input string tag);
    checks++;
    failures++;
    $error("FAIL %s observed=timeout expected=event", tag);
  endtask

  // One cycle: sample at negedge, update scoreboard, resume
  // just after the next rising edge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    chk("used", 64'(used), 64'(q.size()));
    chk("issued", 64'(issued), 64'(iss_m));
    chk("completed", 64'(completed), 64'(cmp_m));
    last_acc = bus.in_valid && bus.in_ready;
    last_pop = bus.out_valid && bus.out_ready;
    last_ov  = bus.out_valid;
    if (last_acc) begin
      q.push_back('{bus.in_tag,
                    nw(bus.in_t_str, bus.in_l_str)});
      iss_m++;
    end
    if (last_pop) begin
      if (q.size() == 0) begin
        expire("pop_on_empty_model");
      end else begin
        chk("out_tag", 64'(bus.out_tag), 64'(q[0].tag));
        chk("out_score", 64'(bus.out_score),
            64'(q[0].score));
        void'(q.pop_front());
      end
      cmp_m++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    tick();
    q.delete();
    iss_m = 0;
    cmp_m = 0;
    rst = 1'b0;
  endtask

  task automatic chk_reset_vals();
    chk("rst_in_ready", 64'(bus.in_ready), 0);
    chk("rst_gvalid", 64'(bus.grid_valid_in), 0);
    chk("rst_gt", 64'(bus.grid_t_str), 0);
    chk("rst_gl", 64'(bus.grid_l_str), 0);
    chk("rst_out_valid", 64'(bus.out_valid), 0);
    chk("rst_out_tag", 64'(bus.out_tag), 0);
    chk("rst_out_score", 64'(bus.out_score), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_used", 64'(used), 0);
    chk("rst_issued", 64'(issued), 0);
    chk("rst_completed", 64'(completed), 0);
    chk("rst_err", 64'(err), 0);
  endtask

  task automatic new_job(input logic [T_W-1:0] tag);
    bus.in_tag   = tag;
    bus.in_t_str = SW'($urandom);
    bus.in_l_str = SW'($urandom);
  endtask

  // Directed single job: latency, issue strobe and literal score.
  task automatic single(input logic [T_W-1:0] tag,
                        input logic [SW-1:0] t,
                        input logic [SW-1:0] l,
                        input logic [S_W-1:0] exp_s);
    int acc_c;
    int n;
    bus.out_ready = 1'b0;
    bus.in_tag    = tag;
    bus.in_t_str  = t;
    bus.in_l_str  = l;
    bus.in_valid  = 1'b1;
    n = 0;
    do begin tick(); n++; end
    while (!last_acc && n < 10);
    if (!last_acc) expire("single_accept");
    acc_c = cyc;
    bus.in_valid = 1'b0;
    chk("gvalid_hi", 64'(bus.grid_valid_in), 1);
    chk("grid_t", 64'(bus.grid_t_str), 64'(t));
    tick();
    chk("gvalid_lo", 64'(bus.grid_valid_in), 0);
    chk("grid_l_hold", 64'(bus.grid_l_str), 64'(l));
    n = 0;
    do begin tick(); n++; end
    while (!last_ov && n < 40);
    if (!last_ov) expire("single_result");
    chk("latency", 64'(cyc - acc_c), 64'(LAT + 2));
    chk("lit_tag", 64'(bus.out_tag), 64'(tag));
    chk("lit_score", 64'(bus.out_score), 64'(exp_s));
    bus.out_ready = 1'b1;
    tick();
    chk("single_popped", 64'(last_pop), 1);
  endtask

  task automatic flush(input string tag);
    int n;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    if (q.size() != 0) expire(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=hang expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, acc_win, tag_n, pop_c, acc_c;
    bus.in_valid  = 1'b0;
    bus.in_tag    = '0;
    bus.in_t_str  = '0;
    bus.in_l_str  = '0;
    bus.out_ready = 1'b0;
    repeat (2) tick();
    do_reset();
    chk_reset_vals();

    enable = 1'b1;
    tick();
    single(8'h5A, 8'hE4, 8'hE4, 8'h04);
    single(8'h11, 8'h00, 8'h55, 8'hFC);
    single(8'h22, 8'hE4, 8'h1B, 8'hFD);

    // Backpressure: only DEPTH credits exist.
    bus.out_ready = 1'b0;
    tag_n = 0;
    acc_win = 0;
    new_job(8'(tag_n));
    bus.in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (last_acc) begin
        acc_win++;
        tag_n++;
        new_job(8'(tag_n));
      end
    end
    chk("bp_accepts", 64'(acc_win), 64'(DEPTH));
    chk("bp_used", 64'(used), 64'(DEPTH));
    chk("bp_ready", 64'(bus.in_ready), 0);
    bus.out_ready = 1'b1;
    pop_c = -1;
    acc_c = -1;
    n = 0;
    while ((tag_n < 20 || q.size() != 0) && n < 300) begin
      tick();
      n++;
      if (last_pop && pop_c < 0) pop_c = cyc;
      if (last_acc && acc_c < 0) acc_c = cyc;
      if (last_acc) begin
        tag_n++;
        new_job(8'(tag_n));
      end
      if (tag_n >= 20) bus.in_valid = 1'b0;
    end
    if (tag_n < 20 || q.size() != 0) expire("bp_finish");
    chk("credit_reuse", 64'(acc_c - pop_c), 1);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      if (last_acc || !bus.in_valid)
        new_job(8'($urandom));
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    flush("rand_flush");
    chk("rand_err", 64'(err), 0);

    // Drain with 5 jobs outstanding.
    do_reset();
    tick();
    tick();
    bus.out_ready = 1'b0;
    tag_n = 0;
    new_job(8'(tag_n));
    bus.in_valid = 1'b1;
    n = 0;
    while (tag_n < 5 && n < 20) begin
      tick();
      n++;
      if (last_acc) begin
        tag_n++;
        new_job(8'(tag_n));
      end
    end
    if (tag_n < 5) expire("drain_fill");
    drain = 1'b1;
    tick();
    chk("drain_ready", 64'(bus.in_ready), 0);
    chk("drain_busy", 64'(busy), 1);
    repeat (LAT + 3) tick();
    bus.out_ready = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      chk("drain_busy_hold", 64'(busy), 1);
      tick();
      n++;
    end
    if (q.size() != 0) expire("drain_empty");
    chk("drain_busy_last", 64'(busy), 1);
    tick();
    tick();
    chk("drain_idle", 64'(busy), 0);
    chk("drain_issued", 64'(issued), 5);
    chk("drain_completed", 64'(completed), 5);
    drain = 1'b0;
    bus.in_valid = 1'b0;

    // Reset with jobs in both the pipe and the FIFO.
    tick();
    tick();
    bus.out_ready = 1'b0;
    tag_n = 0;
    new_job(8'(tag_n));
    bus.in_valid = 1'b1;
    n = 0;
    while (tag_n < 2 && n < 20) begin
      tick();
      n++;
      if (last_acc) begin
        tag_n++;
        new_job(8'(tag_n));
      end
    end
    bus.in_valid = 1'b0;
    repeat (LAT + 3) tick();
    bus.in_valid = 1'b1;
    n = 0;
    while (tag_n < 5 && n < 20) begin
      tick();
      n++;
      if (last_acc) begin
        tag_n++;
        new_job(8'(tag_n));
      end
    end
    if (tag_n < 5) expire("rst_fill");
    bus.in_valid = 1'b0;
    tick();
    chk("pre_rst_used", 64'(used), 5);
    do_reset();
    chk_reset_vals();
    for (int i = 0; i < LAT + 2; i++) begin
      tick();
      chk("no_stale", 64'(bus.out_valid), 0);
    end

    // Spurious grid result with an empty pipe.
    bus.out_ready = 1'b0;
    spur = 1'b1;
    tick();
    spur = 1'b0;
    chk("err_set", 64'(err), 1);
    repeat (5) tick();
    chk("err_held", 64'(err), 1);
    do_reset();
    chk("err_clr", 64'(err), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
